// File: rtl/aurora_watchdog_pkg.sv
// Purpose: shared state encodings and counter widths for the Aurora link watchdog.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aurora_watchdog_pkg;

  localparam int CNT_W   = 28;  // shared down-counter width, holds the largest cycle count
  localparam int RETRY_W = 4;   // consecutive failed attempt counter
  localparam int DROP_W  = 16;  // saturating link drop counter

  // state_o encodings; 6 and 7 are unused and recover to ST_INIT_PULSE
  typedef enum logic [2:0] {
    ST_INIT_PULSE = 3'd0,
    ST_HOLDOFF    = 3'd1,
    ST_WAIT_UP    = 3'd2,
    ST_UP         = 3'd3,
    ST_DEBOUNCE   = 3'd4,
    ST_FAIL       = 3'd5
  } wd_state_e;

endpackage

// File: rtl/aurora_64b66b_0_cdc_sync2.sv
// Purpose: parameterized-width 2-flop synchronizer for asynchronous level signals.
// Latency: 2 cycles from d to q.
// Backpressure: none; free-running sampler.
module aurora_64b66b_0_cdc_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // two back-to-back flops; the first may go metastable, the second settles it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/aurora_64b66b_0_link_watchdog.sv
// Purpose: supervises Aurora channel_up/lane_up, pulses PMA init + core reset and retries up to MAX_RETRIES.
// Latency: 2-cycle input sync, then 1 cycle to registered outputs (outputs decoded from next state).
// Backpressure: none; free-running. Build macro AURORA_WATCHDOG_STATS_EN exposes retry/drop counters.
module aurora_64b66b_0_link_watchdog #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1024,
  parameter int unsigned UP_TIMEOUT_CYCLES = 50000000,
  parameter int unsigned PMA_PULSE_CYCLES  = 16777215,
  parameter int unsigned HOLDOFF_CYCLES    = 4096,
  parameter int unsigned MAX_RETRIES       = 8,
  parameter int          CNT_W             = aurora_watchdog_pkg::CNT_W
) (
  input  logic        INIT_CLK_i,
  input  logic        reset_n_i,
  input  logic        channel_up_i,
  input  logic        lane_up_i,
  input  logic        force_reinit_i,
  input  logic        clear_fail_i,
  output logic        pma_init_o,
  output logic        reset_pb_o,
  output logic        link_ok_o,
  output logic        link_failed_o,
  output logic [2:0]  state_o,
  output logic [3:0]  retry_cnt_o,
  output logic [15:0] drop_cnt_o
);

  import aurora_watchdog_pkg::*;

  logic [1:0]         up_sync;
  logic               ch_up;
  wd_state_e          state;
  wd_state_e          state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               expired;
  logic [RETRY_W-1:0] retry_cnt;
  logic [RETRY_W-1:0] retry_nxt;

  // Reload value for the shared counter on entry to state s. DEBOUNCE loads
  // two less because the first low cycle is already spent in UP, so the drop
  // is declared on exactly the DEBOUNCE_CYCLES-th consecutive low sample.
  function automatic logic [CNT_W-1:0] reload(input wd_state_e s);
    case (s)
      ST_INIT_PULSE: reload = CNT_W'(PMA_PULSE_CYCLES - 1);
      ST_HOLDOFF:    reload = CNT_W'(HOLDOFF_CYCLES - 1);
      ST_WAIT_UP:    reload = CNT_W'(UP_TIMEOUT_CYCLES - 1);
      ST_DEBOUNCE:   reload = CNT_W'(DEBOUNCE_CYCLES - 2);
      default:       reload = '0;
    endcase
  endfunction

  aurora_64b66b_0_cdc_sync2 #(.WIDTH(2)) u_sync (
    .clk   (INIT_CLK_i),
    .rst_n (reset_n_i),
    .d     ({channel_up_i, lane_up_i}),
    .q     (up_sync)
  );

  assign ch_up   = &up_sync;
  assign expired = (cnt == '0);
  assign state_o = state;

  // Next-state and retry bookkeeping; force_reinit takes priority over any expiry.
  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    case (state)
      ST_INIT_PULSE: begin
        if (expired) state_nxt = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (force_reinit_i)  state_nxt = ST_INIT_PULSE;
        else if (expired)    state_nxt = ST_WAIT_UP;
      end
      ST_WAIT_UP: begin
        if (force_reinit_i) begin
          state_nxt = ST_INIT_PULSE;
        end else if (ch_up) begin
          state_nxt = ST_UP;
          retry_nxt = '0;
        end else if (expired) begin
          retry_nxt = retry_cnt + 1'b1;
          state_nxt = (retry_nxt == RETRY_W'(MAX_RETRIES)) ? ST_FAIL : ST_INIT_PULSE;
        end
      end
      ST_UP: begin
        if (force_reinit_i)  state_nxt = ST_INIT_PULSE;
        else if (!ch_up)     state_nxt = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (force_reinit_i)  state_nxt = ST_INIT_PULSE;
        else if (ch_up)      state_nxt = ST_UP;
        else if (expired)    state_nxt = ST_INIT_PULSE;
      end
      ST_FAIL: begin
        if (clear_fail_i || force_reinit_i) begin
          state_nxt = ST_INIT_PULSE;
          retry_nxt = '0;
        end
      end
      default: state_nxt = ST_INIT_PULSE;
    endcase
  end

  // State, counter and outputs; outputs decode state_nxt so they move with the state.
  always_ff @(posedge INIT_CLK_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state         <= ST_INIT_PULSE;
      cnt           <= CNT_W'(PMA_PULSE_CYCLES - 1);
      retry_cnt     <= '0;
      pma_init_o    <= 1'b1;
      reset_pb_o    <= 1'b1;
      link_ok_o     <= 1'b0;
      link_failed_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      retry_cnt <= retry_nxt;
      if (state_nxt != state) cnt <= reload(state_nxt);
      else if (!expired)      cnt <= cnt - 1'b1;
      pma_init_o    <= (state_nxt == ST_INIT_PULSE);
      reset_pb_o    <= (state_nxt == ST_INIT_PULSE) || (state_nxt == ST_HOLDOFF) ||
                       (state_nxt == ST_FAIL);
      link_ok_o     <= (state_nxt == ST_UP) || (state_nxt == ST_DEBOUNCE);
      link_failed_o <= (state_nxt == ST_FAIL);
    end
  end

`ifdef AURORA_WATCHDOG_STATS_EN
  logic [DROP_W-1:0] drop_cnt;
  logic              drop_event;

  assign drop_event  = (state == ST_DEBOUNCE) && !force_reinit_i && !ch_up && expired;
  assign drop_cnt_o  = drop_cnt;
  assign retry_cnt_o = retry_cnt;

  // Saturating count of debounced link drops.
  always_ff @(posedge INIT_CLK_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      drop_cnt <= '0;
    end else if (drop_event && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`else
  assign drop_cnt_o  = '0;
  assign retry_cnt_o = '0;
`endif

endmodule
